// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: memory-op encodings, memory-stage states,
// byte-lane count and small op-classification helpers.
package pipeline_pkg;

    localparam int BYTE_LANES = 4;

    typedef enum logic [2:0] {
        MEM_NONE = 3'd0,
        MEM_LW   = 3'd1,
        MEM_LBU  = 3'd2,
        MEM_LB   = 3'd3,
        MEM_SW   = 3'd4,
        MEM_SB   = 3'd5
    } mem_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } stage_state_e;

    // Encodings 6 and 7 fall through every helper and therefore behave as none.
    function automatic logic op_is_load(input logic [2:0] op);
        return (op == MEM_LW) || (op == MEM_LBU) || (op == MEM_LB);
    endfunction

    function automatic logic op_is_store(input logic [2:0] op);
        return (op == MEM_SW) || (op == MEM_SB);
    endfunction

    // Word accesses are the only ones with an alignment requirement.
    function automatic logic op_is_word(input logic [2:0] op);
        return (op == MEM_LW) || (op == MEM_SW);
    endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Load formatting: picks the little-endian byte lane selected by the low
// address bits and zero/sign extends it, or passes the full word for lw.
module load_align
    import pipeline_pkg::*;
(
    input  logic [2:0]  mem_op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata,
    output logic [31:0] data_out
);

    logic [7:0] byte_s;

    // Byte-lane select followed by extension according to the load type.
    always_comb begin
        case (addr_lo)
            2'd0:    byte_s = rdata[7:0];
            2'd1:    byte_s = rdata[15:8];
            2'd2:    byte_s = rdata[23:16];
            default: byte_s = rdata[31:24];
        endcase
        case (mem_op)
            MEM_LB:  data_out = {{24{byte_s[7]}}, byte_s};
            MEM_LBU: data_out = {24'd0, byte_s};
            default: data_out = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: registers execute-stage results, runs loads/stores
// over a req/ack memory handshake and emits one write-back pulse per
// instruction. Back-pressures the execute stage while an access is pending.
module mem_stage
    import pipeline_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  ex_valid,
    output logic                  ex_ready,
    input  logic [ADDR_W-1:0]     ex_alu_result,
    input  logic [DATA_W-1:0]     ex_store_data,
    input  logic [2:0]            ex_mem_op,
    input  logic [4:0]            ex_dest_reg,
    input  logic                  ex_reg_write,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [BYTE_LANES-1:0] mem_be,
    input  logic                  mem_ack,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  wb_valid,
    output logic [DATA_W-1:0]     wb_data,
    output logic [4:0]            wb_dest_reg,
    output logic                  wb_reg_write,
    output logic                  misaligned
);

    stage_state_e          state_q, state_d;
    logic [2:0]            op_q, op_d;
    logic [1:0]            lane_q, lane_d;
    logic [4:0]            dest_q, dest_d;
    logic                  rw_q, rw_d;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]     mem_wdata_q, mem_wdata_d;
    logic [BYTE_LANES-1:0] mem_be_q, mem_be_d;
    logic                  wb_valid_q, wb_valid_d;
    logic [DATA_W-1:0]     wb_data_q, wb_data_d;
    logic [4:0]            wb_dest_q, wb_dest_d;
    logic                  wb_rw_q, wb_rw_d;
    logic                  mis_q, mis_d;
    logic [31:0]           align_data_s;

    load_align u_load_align (
        .mem_op   (op_q),
        .addr_lo  (lane_q),
        .rdata    (mem_rdata),
        .data_out (align_data_s)
    );

    // Next-state and next-output logic; everything holds unless changed,
    // pulses default low.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        lane_d      = lane_q;
        dest_d      = dest_q;
        rw_d        = rw_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        wb_valid_d  = 1'b0;
        wb_data_d   = wb_data_q;
        wb_dest_d   = wb_dest_q;
        wb_rw_d     = wb_rw_q;
        mis_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (ex_valid) begin
                    if (!op_is_load(ex_mem_op) && !op_is_store(ex_mem_op)) begin
                        // Non-memory instruction: pass straight to write-back.
                        wb_valid_d = 1'b1;
                        wb_data_d  = ex_alu_result;
                        wb_dest_d  = ex_dest_reg;
                        wb_rw_d    = ex_reg_write;
                    end else if (op_is_word(ex_mem_op) && (ex_alu_result[1:0] != 2'b00)) begin
                        // Misaligned word access is dropped without touching memory.
                        mis_d = 1'b1;
                    end else begin
                        state_d    = WAIT;
                        op_d       = ex_mem_op;
                        lane_d     = ex_alu_result[1:0];
                        dest_d     = ex_dest_reg;
                        rw_d       = ex_reg_write;
                        mem_req_d  = 1'b1;
                        mem_we_d   = op_is_store(ex_mem_op);
                        mem_addr_d = {ex_alu_result[ADDR_W-1:2], 2'b00};
                        if (ex_mem_op == MEM_SB) begin
                            mem_be_d    = 4'b0001 << ex_alu_result[1:0];
                            mem_wdata_d = {BYTE_LANES{ex_store_data[7:0]}};
                        end else begin
                            mem_be_d    = 4'b1111;
                            mem_wdata_d = ex_store_data;
                        end
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (mem_ack) begin
                    state_d    = IDLE;
                    mem_req_d  = 1'b0;
                    wb_valid_d = 1'b1;
                    wb_dest_d  = dest_q;
                    if (op_is_load(op_q)) begin
                        wb_data_d = align_data_s;
                        wb_rw_d   = rw_q;
                    end else begin
                        wb_rw_d   = 1'b0;
                    end
                end else begin
                    state_d = WAIT;
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            op_q        <= 3'd0;
            lane_q      <= 2'd0;
            dest_q      <= 5'd0;
            rw_q        <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            wb_valid_q  <= 1'b0;
            wb_data_q   <= '0;
            wb_dest_q   <= 5'd0;
            wb_rw_q     <= 1'b0;
            mis_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            lane_q      <= lane_d;
            dest_q      <= dest_d;
            rw_q        <= rw_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            wb_valid_q  <= wb_valid_d;
            wb_data_q   <= wb_data_d;
            wb_dest_q   <= wb_dest_d;
            wb_rw_q     <= wb_rw_d;
            mis_q       <= mis_d;
        end
    end

    assign ex_ready     = (state_q == IDLE);
    assign mem_req      = mem_req_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign mem_be       = mem_be_q;
    assign wb_valid     = wb_valid_q;
    assign wb_data      = wb_data_q;
    assign wb_dest_reg  = wb_dest_q;
    assign wb_reg_write = wb_rw_q;
    assign misaligned   = mis_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: a word-array reference memory predicts
// every write-back and memory request; a responder process plays the data
// memory and a monitor process compares outputs as they appear.
module tb_mem_stage;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        ex_valid = 1'b0;
    logic        ex_ready;
    logic [31:0] ex_alu_result = 32'd0;
    logic [31:0] ex_store_data = 32'd0;
    logic [2:0]  ex_mem_op = 3'd0;
    logic [4:0]  ex_dest_reg = 5'd0;
    logic        ex_reg_write = 1'b0;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic        wb_valid, wb_reg_write, misaligned;
    logic [31:0] wb_data;
    logic [4:0]  wb_dest_reg;

    mem_stage dut (
        .clock(clock), .reset_n(reset_n), .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data), .ex_mem_op(ex_mem_op),
        .ex_dest_reg(ex_dest_reg), .ex_reg_write(ex_reg_write), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .wb_valid(wb_valid), .wb_data(wb_data),
        .wb_dest_reg(wb_dest_reg), .wb_reg_write(wb_reg_write), .misaligned(misaligned)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit          is_mis;
        bit          chk_data;
        bit          chk_dest;
        logic [31:0] data;
        logic [4:0]  dest;
        logic        rw;
        int          due;
    } wb_exp_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          delay;
    } req_exp_t;

    wb_exp_t     wb_q[$];
    req_exp_t    req_q[$];
    logic [31:0] ref_mem [0:255];
    logic [31:0] dut_mem [0:255];
    int          cyc = 0;
    int          n_pass = 0;
    int          n_total = 0;
    bit          force_ack = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Drive one instruction once the stage is ready; predict its outcome.
    task automatic issue(input logic [2:0] op, input logic [31:0] alu, input logic [31:0] sd,
                         input logic [4:0] dest, input logic rw, input int delay, input bit keep);
        int guard;
        int idx;
        int k;
        int lat;
        bit is_load;
        bit is_store;
        bit is_word;
        logic [31:0] w;
        logic [7:0]  b;
        wb_exp_t  e;
        req_exp_t r;
        @(negedge clock);
        guard = 0;
        while (ex_ready !== 1'b1 && guard < 200) begin
            @(negedge clock);
            guard++;
        end
        if (guard >= 200) begin
            n_total++;
            $display("FAIL ready_timeout: ex_ready low for %0d cycles, required high", guard);
            return;
        end
        ex_valid = 1'b1; ex_mem_op = op; ex_alu_result = alu;
        ex_store_data = sd; ex_dest_reg = dest; ex_reg_write = rw;
        is_load  = (op == 3'd1) || (op == 3'd2) || (op == 3'd3);
        is_store = (op == 3'd4) || (op == 3'd5);
        is_word  = (op == 3'd1) || (op == 3'd4);
        idx = int'(alu[9:2]);
        k   = int'(alu[1:0]);
        w   = ref_mem[idx];
        b   = 8'((w >> (8 * k)) % 256);
        e = '{is_mis: 1'b0, chk_data: 1'b0, chk_dest: 1'b1, data: 32'd0, dest: dest, rw: 1'b0, due: 0};
        r = '{addr: alu - 32'(k), we: 1'b0, be: 4'hF, wdata: 32'd0, delay: delay};
        lat = 1;
        if (!is_load && !is_store) begin
            e.chk_data = 1'b1; e.data = alu; e.rw = rw;
        end else if (is_word && k != 0) begin
            e.is_mis = 1'b1; e.chk_dest = 1'b0;
        end else if (is_load) begin
            lat = 2 + delay;
            e.chk_data = 1'b1; e.rw = rw;
            if (op == 3'd1)      e.data = w;
            else if (op == 3'd2) e.data = 32'(b);
            else                 e.data = (b >= 8'd128) ? 32'(int'(b) - 256) : 32'(b);
            req_q.push_back(r);
        end else begin
            lat = 2 + delay;
            e.chk_dest = 1'b0; e.rw = 1'b0;
            r.we = 1'b1;
            if (op == 3'd4) begin
                r.wdata = sd;
                ref_mem[idx] = sd;
            end else begin
                r.be    = 4'(1 << k);
                r.wdata = 32'(sd[7:0]) * 32'h0101_0101;
                ref_mem[idx] = (w & ~(32'hFF << (8 * k))) | (32'(sd[7:0]) << (8 * k));
            end
            req_q.push_back(r);
        end
        e.due = cyc + lat;
        if (keep) wb_q.push_back(e);
        @(posedge clock);
        #1 ex_valid = 1'b0;
    endtask

    // Monitor: every write-back or misaligned pulse must match the next prediction.
    always @(negedge clock) begin
        wb_exp_t e;
        if (wb_valid === 1'b1 || misaligned === 1'b1) begin
            if (wb_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_output: wb_valid=%0b misaligned=%0b with nothing pending", wb_valid, misaligned);
            end else begin
                e = wb_q.pop_front();
                check("out_cycle", 32'(cyc), 32'(e.due));
                if (e.is_mis) begin
                    check("misaligned", {31'd0, misaligned}, 32'd1);
                    check("mis_no_wb", {31'd0, wb_valid}, 32'd0);
                end else begin
                    check("wb_valid", {31'd0, wb_valid}, 32'd1);
                    check("wb_no_mis", {31'd0, misaligned}, 32'd0);
                    if (e.chk_data) check("wb_data", wb_data, e.data);
                    if (e.chk_dest) check("wb_dest", {27'd0, wb_dest_reg}, {27'd0, e.dest});
                    check("wb_reg_write", {31'd0, wb_reg_write}, {31'd0, e.rw});
                end
            end
        end
    end

    // Memory responder: checks each request, holds it for the planned delay,
    // then acknowledges and applies stores to its own memory image.
    initial begin
        bit          busy;
        int          cnt;
        int          widx;
        logic [31:0] cap_addr, cap_wdata;
        logic [3:0]  cap_be;
        logic        cap_we;
        req_exp_t    r;
        busy = 1'b0; cnt = 0;
        cap_addr = 32'd0; cap_wdata = 32'd0; cap_be = 4'd0; cap_we = 1'b0;
        forever begin
            @(negedge clock);
            mem_ack   = force_ack;
            mem_rdata = $urandom;
            if (mem_req !== 1'b1) begin
                busy = 1'b0;
            end else if (!busy) begin
                if (req_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_request: mem_req=1 addr=0x%08h with no access pending", mem_addr);
                end else begin
                    r = req_q.pop_front();
                    check("req_addr", mem_addr, r.addr);
                    check("req_we", {31'd0, mem_we}, {31'd0, r.we});
                    check("req_be", {28'd0, mem_be}, {28'd0, r.be});
                    if (r.we) check("req_wdata", mem_wdata, r.wdata);
                    cap_addr = mem_addr; cap_wdata = mem_wdata; cap_be = mem_be; cap_we = mem_we;
                    cnt  = r.delay;
                    busy = 1'b1;
                end
            end else begin
                check("hold_addr", mem_addr, cap_addr);
                check("hold_we", {31'd0, mem_we}, {31'd0, cap_we});
                check("hold_be", {28'd0, mem_be}, {28'd0, cap_be});
                check("hold_wdata", mem_wdata, cap_wdata);
            end
            if (busy) begin
                if (cnt == 0) begin
                    widx = int'(cap_addr[9:2]);
                    mem_ack = 1'b1;
                    if (cap_we) begin
                        for (int l = 0; l < 4; l++)
                            if (cap_be[l]) dut_mem[widx][8*l +: 8] = cap_wdata[8*l +: 8];
                    end else begin
                        mem_rdata = dut_mem[widx];
                    end
                    busy = 1'b0;
                end else begin
                    cnt--;
                end
            end
        end
    end

    initial begin
        logic [31:0] v;
        logic [2:0]  op;
        logic [31:0] alu;
        int          guard;
        for (int i = 0; i < 256; i++) begin
            v = $urandom;
            ref_mem[i] = v;
            dut_mem[i] = v;
        end

        // Reset state
        repeat (2) @(negedge clock);
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_mem_be", {28'd0, mem_be}, 32'd0);
        check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_wb_dest", {27'd0, wb_dest_reg}, 32'd0);
        check("rst_wb_rw", {31'd0, wb_reg_write}, 32'd0);
        check("rst_mis", {31'd0, misaligned}, 32'd0);
        check("rst_ex_ready", {31'd0, ex_ready}, 32'd1);
        reset_n = 1'b1;

        // Non-memory ops back to back
        issue(3'd0, 32'h0000_0042, 32'd0, 5'd5, 1'b1, 0, 1'b1);
        issue(3'd0, 32'h0000_1234, 32'd0, 5'd7, 1'b0, 0, 1'b1);
        issue(3'd7, 32'hCAFE_0001, 32'd0, 5'd9, 1'b1, 0, 1'b1);
        @(negedge clock);
        check("t1_ex_ready", {31'd0, ex_ready}, 32'd1);

        // lw with immediate ack
        ref_mem[64] = 32'hDEAD_BEEF; dut_mem[64] = 32'hDEAD_BEEF;
        issue(3'd1, 32'h0000_0100, 32'd0, 5'd3, 1'b1, 0, 1'b1);
        @(negedge clock);
        check("t2_ex_ready_wait", {31'd0, ex_ready}, 32'd0);
        check("t2_mem_req", {31'd0, mem_req}, 32'd1);

        // lb / lbu on the top byte lane
        ref_mem[64] = 32'h80FF_FF7F; dut_mem[64] = 32'h80FF_FF7F;
        issue(3'd3, 32'h0000_0103, 32'd0, 5'd4, 1'b1, 1, 1'b1);
        issue(3'd2, 32'h0000_0103, 32'd0, 5'd6, 1'b1, 0, 1'b1);

        // sb with a delayed ack
        issue(3'd5, 32'h0000_0202, 32'h1234_56AB, 5'd9, 1'b1, 3, 1'b1);

        // Misaligned sw
        issue(3'd4, 32'h0000_0301, 32'h0000_CAFE, 5'd2, 1'b1, 0, 1'b1);
        repeat (3) begin
            @(negedge clock);
            check("t5_no_req", {31'd0, mem_req}, 32'd0);
        end

        // Reset while waiting, then a stray ack
        issue(3'd1, 32'h0000_0104, 32'd0, 5'd8, 1'b1, 50, 1'b0);
        @(negedge clock);
        check("t6_req_before", {31'd0, mem_req}, 32'd1);
        reset_n = 1'b0;
        @(negedge clock);
        check("t6_req_after", {31'd0, mem_req}, 32'd0);
        check("t6_ready_after", {31'd0, ex_ready}, 32'd1);
        check("t6_wb_after", {31'd0, wb_valid}, 32'd0);
        check("t6_addr_after", mem_addr, 32'd0);
        reset_n = 1'b1;
        @(posedge clock);
        #1 force_ack = 1'b1;
        @(posedge clock);
        #1 force_ack = 1'b0;
        repeat (3) begin
            @(negedge clock);
            check("t6_late_ack_wb", {31'd0, wb_valid}, 32'd0);
            check("t6_late_ack_req", {31'd0, mem_req}, 32'd0);
        end

        // Randomized traffic against the reference memory
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 3) == 0) @(negedge clock);
            op = 3'($urandom_range(0, 7));
            if (op >= 3'd1 && op <= 3'd5) begin
                alu = 32'h100 + 32'($urandom_range(0, 255));
                if ((op == 3'd1 || op == 3'd4) && $urandom_range(0, 3) != 0) alu = alu & ~32'd3;
            end else begin
                alu = $urandom;
            end
            issue(op, alu, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 3)), 1'b1);
        end

        // Drain
        guard = 0;
        while ((wb_q.size() != 0 || req_q.size() != 0) && guard < 500) begin
            @(negedge clock);
            guard++;
        end
        if (guard >= 500) begin
            n_total++;
            $display("FAIL drain_timeout: %0d write-backs and %0d requests still pending, required 0",
                     wb_q.size(), req_q.size());
        end
        repeat (3) @(negedge clock);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
